slave_fifo_arbiter: RTL and testbench



---
 rtl/redirector_pkg.sv | 15 +
 rtl/rr_arbiter_2.sv | 18 +
 rtl/slave_fifo_arbiter.sv | 128 ++++++++++++
 tb/tb_slave_fifo_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/redirector_pkg.sv
// Shared definitions for the slave-FIFO redirector: FSM states and the
// default header tag / endpoint address.
package redirector_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    DATA   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [7:0] DEF_HDR_TAG = 8'hA5;
  localparam logic [1:0] DEF_EP_ADDR = 2'b10;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: the source served last loses a tie.
// Purely combinational; grant is all-zero unless update is high.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       update,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (update) begin
      if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
      else              grant = req;
    end
  end

endmodule

// File: rtl/slave_fifo_arbiter.sv
// Arbitrates two message FIFOs onto a Cypress slave-FIFO IN endpoint: header word,
// MSG_WORDS payload words, then PKTEND. Writes stall while FLAG_FULL is low (full).
module slave_fifo_arbiter
  import redirector_pkg::*;
#(
  parameter int         MSG_WORDS = 8,
  parameter logic [1:0] EP_ADDR   = DEF_EP_ADDR,
  parameter logic [7:0] HDR_TAG   = DEF_HDR_TAG
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic [1:0]  GOT_FULL_MSG,
  input  logic [15:0] FIFO_Q0,
  input  logic [15:0] FIFO_Q1,
  output logic [1:0]  RD_REQ,
  input  logic        FLAG_FULL,
  output logic [15:0] FD_OUT,
  output logic        FD_OE,
  output logic        SLWR,
  output logic        SLRD,
  output logic        SLOE,
  output logic [1:0]  FIFOADR,
  output logic        PKTEND,
  output logic [1:0]  GRANT,
  output logic        BUSY
);

  localparam logic [7:0] LAST_IDX = 8'(MSG_WORDS - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        last, last_nxt;
  logic [1:0]  grant_q, grant_nxt;
  logic [15:0] fd_q, fd_nxt;
  logic        slwr_q, slwr_nxt;
  logic        pktend_q, pktend_nxt;
  logic [1:0]  arb_grant;
  logic        src;
  logic        wr;

  assign src = grant_q[1];
  assign wr  = ((state == HDR) || (state == DATA)) && FLAG_FULL;

  rr_arbiter_2 u_rr (
    .req    (GOT_FULL_MSG),
    .last   (last),
    .update ((state == IDLE) && ENABLE),
    .grant  (arb_grant)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_nxt   = last;
    grant_nxt  = grant_q;
    fd_nxt     = fd_q;
    slwr_nxt   = 1'b1;
    pktend_nxt = 1'b1;
    case (state)
      IDLE: begin
        if (arb_grant != 2'b00) begin
          grant_nxt = arb_grant;
          state_nxt = HDR;
        end
      end
      HDR: begin
        if (wr) begin
          fd_nxt    = {HDR_TAG, 7'b0, src};
          slwr_nxt  = 1'b0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (wr) begin
          fd_nxt   = src ? FIFO_Q1 : FIFO_Q0;
          slwr_nxt = 1'b0;
          if (cnt == LAST_IDX) begin
            cnt_nxt   = 8'd0;
            state_nxt = COMMIT;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      COMMIT: begin
        pktend_nxt = 1'b0;
        last_nxt   = src;
        grant_nxt  = 2'b00;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      last     <= 1'b1;
      grant_q  <= 2'b00;
      fd_q     <= 16'd0;
      slwr_q   <= 1'b1;
      pktend_q <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      grant_q  <= grant_nxt;
      fd_q     <= fd_nxt;
      slwr_q   <= slwr_nxt;
      pktend_q <= pktend_nxt;
    end
  end

  // Read acknowledge is combinational so the show-ahead word advances on the same edge it is captured.
  assign RD_REQ  = (state == DATA && wr && !RST) ? (src ? 2'b10 : 2'b01) : 2'b00;
  assign FD_OUT  = fd_q;
  assign SLWR    = slwr_q;
  assign PKTEND  = pktend_q;
  assign GRANT   = grant_q;
  assign BUSY    = (state != IDLE);
  assign FD_OE   = BUSY;
  assign SLRD    = 1'b1;
  assign SLOE    = 1'b1;
  assign FIFOADR = EP_ADDR;

endmodule

// File: tb/tb_slave_fifo_arbiter.sv
// Bench for slave_fifo_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a message-level reference model.
module tb_slave_fifo_arbiter;

  localparam int MSG = 8;

  logic        CLK = 1'b0;
  logic        rst, en, ff;
  logic [1:0]  req;
  logic [15:0] q0, q1;
  logic [1:0]  RD_REQ;
  logic [15:0] FD_OUT;
  logic        FD_OE, SLWR, SLRD, SLOE, PKTEND, BUSY;
  logic [1:0]  FIFOADR, GRANT;

  always #5 CLK = ~CLK;

  slave_fifo_arbiter #(.MSG_WORDS(MSG)) dut (
    .CLK(CLK), .RST(rst), .ENABLE(en), .GOT_FULL_MSG(req),
    .FIFO_Q0(q0), .FIFO_Q1(q1), .RD_REQ(RD_REQ), .FLAG_FULL(ff),
    .FD_OUT(FD_OUT), .FD_OE(FD_OE), .SLWR(SLWR), .SLRD(SLRD), .SLOE(SLOE),
    .FIFOADR(FIFOADR), .PKTEND(PKTEND), .GRANT(GRANT), .BUSY(BUSY)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Source FIFO contents; the bench pops on RD_REQ, the model keeps its own read pointers.
  logic [15:0] src_mem [2][1024];
  int d_ptr [2];
  int m_ptr [2];

  // Reference model: where we are within a message.
  logic        m_busy = 1'b0;
  logic        m_hdr  = 1'b0;
  logic        m_src  = 1'b0;
  logic        m_last = 1'b1;
  int          m_left = 0;
  logic [15:0] e_fd   = 16'd0;
  logic        e_slwr, e_pkt;

  // Observation logs.
  logic [15:0] hdr_log [$];
  logic [15:0] wlog [$];
  logic        want_hdr = 1'b1;
  int rd_count = 0, pk_count = 0, cur_run = 0, max_run = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic show_fifos();
    q0 = src_mem[0][d_ptr[0] % 1024];
    q1 = src_mem[1][d_ptr[1] % 1024];
  endtask

  task automatic cycle();
    logic [1:0] exp_rd;
    logic [1:0] rd_seen;
    logic       was_rst;
    #1;
    exp_rd = 2'b00;
    if (!rst && m_busy && !m_hdr && m_left > 0 && ff) exp_rd = m_src ? 2'b10 : 2'b01;
    rd_seen = RD_REQ;
    check("rd_req", {30'd0, rd_seen}, {30'd0, exp_rd});
    e_slwr  = 1'b1;
    e_pkt   = 1'b1;
    was_rst = rst;
    if (rst) begin
      m_busy = 1'b0; m_hdr = 1'b0; m_last = 1'b1; m_left = 0; e_fd = 16'd0;
    end else if (!m_busy) begin
      if (en && req != 2'b00) begin
        m_src  = (req == 2'b11) ? ~m_last : req[1];
        m_busy = 1'b1; m_hdr = 1'b1; m_left = MSG;
      end
    end else if (m_hdr) begin
      if (ff) begin
        e_fd = {8'hA5, 7'b0, m_src}; e_slwr = 1'b0; m_hdr = 1'b0;
      end
    end else if (m_left > 0) begin
      if (ff) begin
        e_fd = src_mem[m_src][m_ptr[m_src] % 1024];
        m_ptr[m_src]++;
        e_slwr = 1'b0; m_left--;
      end
    end else begin
      e_pkt = 1'b0; m_last = m_src; m_busy = 1'b0;
    end

    @(posedge CLK);
    #1;
    for (int s = 0; s < 2; s++) if (rd_seen[s]) begin d_ptr[s]++; rd_count++; end
    show_fifos();

    check("slwr",    {31'd0, SLWR},    {31'd0, e_slwr});
    check("pktend",  {31'd0, PKTEND},  {31'd0, e_pkt});
    check("fd_out",  {16'd0, FD_OUT},  {16'd0, e_fd});
    check("busy",    {31'd0, BUSY},    {31'd0, m_busy});
    check("fd_oe",   {31'd0, FD_OE},   {31'd0, m_busy});
    check("grant",   {30'd0, GRANT},   {30'd0, (m_busy ? (m_src ? 2'b10 : 2'b01) : 2'b00)});
    check("slrd",    {31'd0, SLRD},    32'd1);
    check("sloe",    {31'd0, SLOE},    32'd1);
    check("fifoadr", {30'd0, FIFOADR}, 32'd2);

    if (SLWR == 1'b0) begin
      wlog.push_back(FD_OUT);
      if (want_hdr) begin hdr_log.push_back(FD_OUT); want_hdr = 1'b0; end
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    if (PKTEND == 1'b0) begin pk_count++; want_hdr = 1'b1; end
    if (was_rst) want_hdr = 1'b1;
  endtask

  task automatic wait_msgs(input int n, input int budget);
    int start;
    start = pk_count;
    for (int i = 0; i < budget && pk_count < start + n; i++) cycle();
    check("msg_done", pk_count - start, n);
  endtask

  task automatic wait_words(input int n, input int budget);
    int i;
    for (i = 0; i < budget && !(m_busy && !m_hdr && (MSG - m_left) >= n); i++) cycle();
    check("words_reached", (i < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int rd0, pk0, stall_rd;
    logic [15:0] h0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) src_mem[s][i] = 16'($urandom);
    for (int i = 0; i < MSG; i++) src_mem[0][i] = 16'(i + 1);
    d_ptr[0] = 0; d_ptr[1] = 0; m_ptr[0] = 0; m_ptr[1] = 0;
    show_fifos();
    rst = 1'b1; en = 1'b1; ff = 1'b1; req = 2'b00;
    @(posedge CLK); #1;
    cycle(); cycle();
    check("rst_rd_req", {30'd0, RD_REQ}, 32'd0);
    rst = 1'b0;
    cycle();

    // Single request from source 0, no stall.
    wlog.delete(); rd0 = rd_count; max_run = 0; cur_run = 0;
    req = 2'b01;
    wait_msgs(1, 40);
    req = 2'b00;
    check("single_len", wlog.size(), MSG + 1);
    check("single_hdr", {16'd0, wlog[0]}, 32'h0000A500);
    for (int i = 1; i <= MSG && i < wlog.size(); i++) check("single_word", {16'd0, wlog[i]}, i);
    check("single_run", max_run, MSG + 1);
    check("single_rd", rd_count - rd0, MSG);
    repeat (3) cycle();

    // Contention over three messages.
    hdr_log.delete();
    req = 2'b11;
    wait_msgs(3, 60);
    req = 2'b00;
    check("cont_cnt", hdr_log.size(), 3);
    if (hdr_log.size() == 3) begin
      check("cont_h0", {16'd0, hdr_log[0]}, 32'h0000A501);
      check("cont_h1", {16'd0, hdr_log[1]}, 32'h0000A500);
      check("cont_h2", {16'd0, hdr_log[2]}, 32'h0000A501);
    end
    repeat (2) cycle();

    // Full stall after the third payload word.
    rd0 = rd_count; req = 2'b10;
    wait_words(3, 30);
    req = 2'b00;
    ff = 1'b0; stall_rd = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (RD_REQ != 2'b00) stall_rd++;
    end
    check("stall_rd", stall_rd, 0);
    ff = 1'b1;
    wait_msgs(1, 40);
    check("stall_rd_total", rd_count - rd0, MSG);

    // Enable low with requests pending, then drop enable mid-message.
    en = 1'b0; req = 2'b11;
    repeat (10) cycle();
    check("en_busy", {31'd0, BUSY}, 32'd0);
    en = 1'b1;
    wait_words(2, 20);
    en = 1'b0;
    wait_msgs(1, 40);
    req = 2'b00; en = 1'b1;
    repeat (2) cycle();

    // Reset in the middle of a payload.
    req = 2'b11; pk0 = pk_count;
    wait_words(2, 20);
    rst = 1'b1;
    cycle();
    rst = 1'b0; req = 2'b00;
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_slwr", {31'd0, SLWR}, 32'd1);
    check("rst_fd",   {16'd0, FD_OUT}, 32'd0);
    cycle();
    check("rst_no_pktend", pk_count - pk0, 0);
    hdr_log.delete(); req = 2'b11;
    repeat (4) cycle();
    h0 = (hdr_log.size() > 0) ? hdr_log[0] : 16'hFFFF;
    check("rst_next_src0", {16'd0, h0}, 32'h0000A500);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      req = 2'($urandom);
      ff  = ($urandom_range(0, 3) != 0);
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 199) == 0) rst = 1'b1; else rst = 1'b0;
      cycle();
    end
    rst = 1'b0; req = 2'b00; ff = 1'b1;
    repeat (20) cycle();
    check("end_idle", {31'd0, BUSY}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
